// File: rtl/lpc_mm_pkg.sv
// Shared definitions for the stream write master: CSR map, status bits, FSM states.
`timescale 1ns/1ps
package lpc_mm_pkg;

  localparam logic [2:0] REG_BASE   = 3'd0;
  localparam logic [2:0] REG_LENGTH = 3'd1;
  localparam logic [2:0] REG_STEP   = 3'd2;
  localparam logic [2:0] REG_COUNT  = 3'd3;
  localparam logic [2:0] REG_START  = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;
  localparam logic [2:0] REG_RESET  = 3'd6;

  localparam int STAT_DONE = 0;
  localparam int STAT_BUSY = 1;
  localparam int STAT_OVF  = 2;

  localparam logic [31:0] READ_DEFAULT = 32'hDEADBEEF;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a push on a full FIFO is taken only when a pop frees a slot.
`timescale 1ns/1ps
module sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]    count_reg;
  logic              do_push, do_pop;

  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage is not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/stream_write_master.sv
// Captures a qualified sample stream into a FIFO and writes it to DDR through an
// Avalon-MM write master, configured and started through a small CSR slave.
`timescale 1ns/1ps
module stream_write_master
  import lpc_mm_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] ddr_addr,
  output logic              ddr_write,
  output logic [DATA_W-1:0] ddr_writedata,
  input  logic              ddr_waitrequest,
  input  logic [2:0]        addr,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [DATA_W-1:0] d_in,
  input  logic              vin,
  output logic              overflow
);

  state_t state_reg, state_next;

  logic [ADDR_W-1:0] base_reg, step_reg, step_run_reg, addr_cur_reg, ddr_addr_reg;
  logic [31:0]       length_reg, count_reg, remaining_reg, run_len_reg, accepted_reg;
  logic [31:0]       readdata_reg, rd_mux;
  logic [DATA_W-1:0] ddr_writedata_reg, fifo_dout;
  logic              ddr_write_reg, done_reg, overflow_reg;
  logic              clr, start_hit, accept, last_accept, pop, want_push, push, drop;
  logic              fifo_full, fifo_empty;

  assign clr         = rst || (write && addr == REG_RESET);
  assign start_hit   = write && addr == REG_START && state_reg != RUN;
  assign accept      = ddr_write_reg && !ddr_waitrequest;
  assign last_accept = accept && remaining_reg == 32'd1;
  // Issue when idle on the bus, or back-to-back on acceptance unless that was the last word.
  assign pop         = state_reg == RUN && !fifo_empty &&
                       (!ddr_write_reg || (accept && remaining_reg > 32'd1));
  assign want_push   = state_reg == RUN && vin && accepted_reg < run_len_reg;
  assign push        = want_push && (!fifo_full || pop);
  assign drop        = want_push && fifo_full && !pop;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (clr || start_hit),
    .push  (push),
    .pop   (pop),
    .din   (d_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE, DONE: if (start_hit) state_next = (length_reg == 32'd0) ? DONE : RUN;
      RUN:        if (last_accept) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    rd_mux = READ_DEFAULT;
    case (addr)
      REG_BASE:   rd_mux = 32'(base_reg);
      REG_LENGTH: rd_mux = length_reg;
      REG_STEP:   rd_mux = 32'(step_reg);
      REG_COUNT:  rd_mux = count_reg;
      REG_STATUS: rd_mux = {29'd0, overflow_reg, state_reg == RUN, done_reg};
      default:    rd_mux = READ_DEFAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      base_reg          <= '0;
      length_reg        <= '0;
      step_reg          <= ADDR_W'(1);
      step_run_reg      <= ADDR_W'(1);
      count_reg         <= '0;
      remaining_reg     <= '0;
      run_len_reg       <= '0;
      accepted_reg      <= '0;
      addr_cur_reg      <= '0;
      ddr_addr_reg      <= '0;
      ddr_writedata_reg <= '0;
      ddr_write_reg     <= 1'b0;
      readdata_reg      <= '0;
      done_reg          <= 1'b0;
      overflow_reg      <= 1'b0;
    end else begin
      if (write && addr == REG_BASE)   base_reg   <= ADDR_W'(writedata);
      if (write && addr == REG_LENGTH) length_reg <= writedata;
      if (write && addr == REG_STEP)   step_reg   <= ADDR_W'(writedata);
      if (read) readdata_reg <= rd_mux;

      if (start_hit) begin
        // The run works on private copies so config writes mid-run have no effect.
        addr_cur_reg  <= base_reg;
        step_run_reg  <= step_reg;
        remaining_reg <= length_reg;
        run_len_reg   <= length_reg;
        accepted_reg  <= '0;
        count_reg     <= '0;
        done_reg      <= (length_reg == 32'd0);
        overflow_reg  <= 1'b0;
        ddr_write_reg <= 1'b0;
      end else begin
        if (push) accepted_reg <= accepted_reg + 32'd1;
        if (drop) overflow_reg <= 1'b1;
        if (accept) begin
          count_reg     <= count_reg + 32'd1;
          remaining_reg <= remaining_reg - 32'd1;
          ddr_write_reg <= 1'b0;
          if (last_accept) done_reg <= 1'b1;
        end
        if (pop) begin
          ddr_write_reg     <= 1'b1;
          ddr_addr_reg      <= addr_cur_reg;
          ddr_writedata_reg <= fifo_dout;
          addr_cur_reg      <= addr_cur_reg + step_run_reg;
        end
      end
    end
  end

  assign ddr_addr      = ddr_addr_reg;
  assign ddr_write     = ddr_write_reg;
  assign ddr_writedata = ddr_writedata_reg;
  assign readdata      = readdata_reg;
  assign overflow      = overflow_reg;

endmodule

// File: tb/tb_stream_write_master.sv
// Directed bench for stream_write_master: CSR programming, DDR write capture and
// immediate-assertion checks against hand-computed expectations.
`timescale 1ns/1ps
module tb_stream_write_master;
  import lpc_mm_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ddr_addr;
  logic        ddr_write;
  logic [15:0] ddr_writedata;
  logic        ddr_waitrequest;
  logic [2:0]  addr;
  logic        read, write;
  logic [31:0] writedata, readdata;
  logic [15:0] d_in;
  logic        vin, overflow;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] wr_addr [64];
  logic [15:0] wr_data [64];
  int          wr_n = 0;

  stream_write_master #(.DATA_W(16), .ADDR_W(32), .FIFO_DEPTH(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .ddr_addr        (ddr_addr),
    .ddr_write       (ddr_write),
    .ddr_writedata   (ddr_writedata),
    .ddr_waitrequest (ddr_waitrequest),
    .addr            (addr),
    .read            (read),
    .write           (write),
    .writedata       (writedata),
    .readdata        (readdata),
    .d_in            (d_in),
    .vin             (vin),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  // Record every accepted DDR write.
  always @(posedge clk) begin
    if (ddr_write && !ddr_waitrequest && wr_n < 64) begin
      wr_addr[wr_n] <= ddr_addr;
      wr_data[wr_n] <= ddr_writedata;
      wr_n          <= wr_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
    write = 1'b1; addr = a; writedata = d;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
    read = 1'b1; addr = a;
    @(negedge clk);
    read = 1'b0;
    d = readdata;
  endtask

  task automatic feed(input logic [15:0] d);
    vin = 1'b1; d_in = d;
    @(negedge clk);
    vin = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 200 && !r[STAT_DONE]; k++) csr_read(REG_STATUS, r);
    check(tag, {31'd0, r[STAT_DONE]}, 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    logic [15:0] exp1 [4];
    int n0;
    exp1 = '{16'h0001, 16'hFFFE, 16'h0003, 16'hFFFC};

    rst = 1'b1; ddr_waitrequest = 1'b0; addr = '0; read = 1'b0; write = 1'b0;
    writedata = '0; d_in = '0; vin = 1'b0;
    repeat (3) tick();
    check("rst_ddr_write", {31'd0, ddr_write}, 32'd0);
    check("rst_ddr_addr", ddr_addr, 32'd0);
    check("rst_ddr_data", {16'd0, ddr_writedata}, 32'd0);
    check("rst_readdata", readdata, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    tick();
    csr_read(REG_BASE, r);   check("rst_base", r, 32'd0);
    csr_read(REG_STEP, r);   check("rst_step", r, 32'd1);
    csr_read(REG_STATUS, r); check("rst_status", r, 32'd0);

    // Basic run with signed samples and latency check.
    csr_write(REG_BASE, 32'h100);
    csr_write(REG_LENGTH, 32'd4);
    csr_write(REG_STEP, 32'd1);
    n0 = wr_n;
    csr_write(REG_START, 32'd0);
    vin = 1'b1; d_in = exp1[0];
    tick(); check("lat_t1", {31'd0, ddr_write}, 32'd0);
    d_in = exp1[1];
    tick(); check("lat_t2", {31'd0, ddr_write}, 32'd1);
    d_in = exp1[2];
    tick();
    d_in = exp1[3];
    tick();
    vin = 1'b0;
    wait_done("basic_done");
    check("basic_nwr", wr_n - n0, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("basic_addr", wr_addr[n0+i], 32'h100 + i);
      check("basic_data", {16'd0, wr_data[n0+i]}, {16'd0, exp1[i]});
    end
    csr_read(REG_COUNT, r);  check("basic_count", r, 32'd4);
    csr_read(REG_STATUS, r); check("basic_status", r, 32'd1);
    check("basic_ovf", {31'd0, overflow}, 32'd0);

    // Stall hold: first write held 5 cycles under waitrequest.
    csr_write(REG_LENGTH, 32'd2);
    ddr_waitrequest = 1'b1;
    n0 = wr_n;
    csr_write(REG_START, 32'd0);
    feed(16'h1111);
    feed(16'h2222);
    for (int i = 0; i < 5; i++) begin
      check("stall_write", {31'd0, ddr_write}, 32'd1);
      check("stall_addr", ddr_addr, 32'h100);
      check("stall_data", {16'd0, ddr_writedata}, 32'h1111);
      tick();
    end
    ddr_waitrequest = 1'b0;
    wait_done("stall_done");
    check("stall_nwr", wr_n - n0, 32'd2);
    check("stall_addr0", wr_addr[n0], 32'h100);
    check("stall_data0", {16'd0, wr_data[n0]}, 32'h1111);
    check("stall_addr1", wr_addr[n0+1], 32'h101);
    check("stall_data1", {16'd0, wr_data[n0+1]}, 32'h2222);

    // Step of 2 with extra samples beyond length.
    csr_write(REG_BASE, 32'h0);
    csr_write(REG_STEP, 32'd2);
    csr_write(REG_LENGTH, 32'd3);
    n0 = wr_n;
    csr_write(REG_START, 32'd0);
    for (int i = 0; i < 5; i++) feed(16'(10 + i));
    repeat (5) tick();
    wait_done("step_done");
    check("step_nwr", wr_n - n0, 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("step_addr", wr_addr[n0+i], 32'(2 * i));
      check("step_data", {16'd0, wr_data[n0+i]}, 32'(10 + i));
    end
    csr_read(REG_STATUS, r); check("step_status", r, 32'd1);

    // Overflow: one word in the stalled write, eight buffered, three dropped.
    csr_write(REG_BASE, 32'h200);
    csr_write(REG_STEP, 32'd1);
    csr_write(REG_LENGTH, 32'd20);
    ddr_waitrequest = 1'b1;
    n0 = wr_n;
    csr_write(REG_START, 32'd0);
    for (int i = 0; i < 12; i++) feed(16'(16'h40 + i));
    csr_read(REG_STATUS, r); check("ovf_status", r, 32'd6);
    check("ovf_pin", {31'd0, overflow}, 32'd1);
    ddr_waitrequest = 1'b0;
    repeat (20) tick();
    check("ovf_nwr_drain", wr_n - n0, 32'd9);
    for (int i = 0; i < 9; i++) begin
      check("ovf_data", {16'd0, wr_data[n0+i]}, 32'(16'h40 + i));
      check("ovf_addr", wr_addr[n0+i], 32'h200 + i);
    end
    for (int j = 0; j < 11; j++) feed(16'(16'h80 + j));
    wait_done("ovf_done");
    check("ovf_nwr", wr_n - n0, 32'd20);
    check("ovf_last_data", {16'd0, wr_data[n0+19]}, 32'h8A);
    check("ovf_last_addr", wr_addr[n0+19], 32'h213);
    csr_read(REG_STATUS, r); check("ovf_status_end", r, 32'd5);

    // Zero length then a one-sample restart.
    csr_write(REG_BASE, 32'h300);
    csr_write(REG_LENGTH, 32'd0);
    n0 = wr_n;
    csr_write(REG_START, 32'd0);
    csr_read(REG_STATUS, r); check("zero_status", r, 32'd1);
    repeat (3) tick();
    check("zero_nwr", wr_n - n0, 32'd0);
    csr_write(REG_LENGTH, 32'd1);
    csr_write(REG_START, 32'd0);
    csr_read(REG_STATUS, r); check("restart_busy", r, 32'd2);
    feed(16'h5A5A);
    wait_done("restart_done");
    check("restart_nwr", wr_n - n0, 32'd1);
    check("restart_addr", wr_addr[n0], 32'h300);
    check("restart_data", {16'd0, wr_data[n0]}, 32'h5A5A);

    // Soft reset during a stalled write.
    csr_write(REG_LENGTH, 32'd4);
    ddr_waitrequest = 1'b1;
    n0 = wr_n;
    csr_write(REG_START, 32'd0);
    feed(16'h7777);
    tick();
    check("srst_pre_write", {31'd0, ddr_write}, 32'd1);
    csr_write(REG_RESET, 32'd0);
    check("srst_write", {31'd0, ddr_write}, 32'd0);
    check("srst_addr", ddr_addr, 32'd0);
    check("srst_data", {16'd0, ddr_writedata}, 32'd0);
    check("srst_readdata", readdata, 32'd0);
    csr_read(REG_STATUS, r); check("srst_status", r, 32'd0);
    csr_read(REG_BASE, r);   check("srst_base", r, 32'd0);
    csr_read(REG_LENGTH, r); check("srst_length", r, 32'd0);
    csr_read(REG_STEP, r);   check("srst_step", r, 32'd1);
    csr_read(REG_COUNT, r);  check("srst_count", r, 32'd0);
    csr_read(3'd7, r);       check("read_undef", r, 32'hDEADBEEF);
    csr_read(REG_START, r);  check("read_start_wo", r, 32'hDEADBEEF);
    ddr_waitrequest = 1'b0;
    repeat (3) tick();
    check("srst_nwr", wr_n - n0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
